hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: MIPS 5-stage hazard, forwarding and data-memory wait-state control.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t state, state_next;
  logic [WW-1:0] wcnt, wcnt_next;
  logic memstall, lwstall, brstall;
  // register 0 never produces a match
  function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction
  assign ForwardAE = (RegWriteM && hit(RsE, WriteRegM)) ? 2'b10 :
                     (RegWriteW && hit(RsE, WriteRegW)) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && hit(RtE, WriteRegM)) ? 2'b10 :
                     (RegWriteW && hit(RtE, WriteRegW)) ? 2'b01 : 2'b00;
  assign ForwardAD = RegWriteM && hit(RsD, WriteRegM);
  assign ForwardBD = RegWriteM && hit(RtD, WriteRegM);
  assign lwstall = MemtoRegE && (hit(RsD, RtE) || hit(RtD, RtE));
  assign brstall = BranchD &&
                   ((RegWriteE && (hit(RsD, WriteRegE) || hit(RtD, WriteRegE))) ||
                    (MemtoRegM && (hit(RsD, WriteRegM) || hit(RtD, WriteRegM))));
  always_comb begin
    state_next = state;
    wcnt_next = wcnt;
    memstall = 1'b0;
    unique case (state)
      RUN: begin
        memstall = MemReqM && !MemReadyM;
        if (memstall) begin
          state_next = WAIT;
          wcnt_next = WW'(1);
        end
      end
      WAIT: begin
        memstall = !MemReadyM;
        if (MemReadyM) begin
          state_next = RUN;
          wcnt_next = '0;
        end else if (wcnt == LAST) state_next = ERR;
        else wcnt_next = wcnt + WW'(1);
      end
      ERR: memstall = 1'b1;
      default: state_next = RUN;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= RUN;
      wcnt <= '0;
    end else begin
      state <= state_next;
      wcnt <= wcnt_next;
    end
  end
  assign StallF = lwstall || brstall || memstall;
  assign StallD = StallF;
  assign StallE = memstall;
  assign StallM = memstall;
  assign FlushW = memstall;
  // a memory stall freezes E rather than inserting a bubble
  assign FlushE = (lwstall || brstall) && !memstall;
  assign MemErr = (state == ERR);
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && !(&StallCnt)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushE && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif
endmodule
